// File: rtl/alu32_pkg.sv
// Shared constants for the tinycpu execute-stage ALU: widths, opcodes and shifter modes.
package alu32_pkg;

    localparam int ALU_DATA_WIDTH  = 32;
    localparam int ALU_CTRL_WIDTH  = 4;
    localparam int ALU_SHAMT_WIDTH = 5;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR    = 4'b0001;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD   = 4'b0010;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR   = 4'b0011;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL   = 4'b0100;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL   = 4'b0101;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB   = 4'b0110;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT   = 4'b0111;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PASSA = 4'b1000;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PASSB = 4'b1001;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LUI   = 4'b1010;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU  = 4'b1011;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_NOR   = 4'b1100;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA   = 4'b1110;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;

endpackage

// File: rtl/alu32_shifter.sv
// Combinational log-depth barrel shifter for SLL/SRL/SRA; one stage per shift-amount bit.
module alu32_shifter
    import alu32_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]      data,
    input  logic [ALU_SHAMT_WIDTH-1:0] shamt,
    input  logic [1:0]                 mode,
    output logic [DATA_WIDTH-1:0]      shifted
);

    logic [DATA_WIDTH-1:0] stage [0:ALU_SHAMT_WIDTH];
    logic                  shift_left;
    logic                  fill_bit;

    assign shift_left = (mode == SHIFT_SLL);
    // Right shifts fill with the original sign bit only in arithmetic mode.
    assign fill_bit   = (mode == SHIFT_SRA) && data[DATA_WIDTH-1];
    assign stage[0]   = data;

    genvar gi;
    generate
        for (gi = 0; gi < ALU_SHAMT_WIDTH; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = !shamt[gi] ? stage[gi] :
                                 shift_left ? {stage[gi][DATA_WIDTH-1-SH:0], {SH{1'b0}}} :
                                              {{SH{fill_bit}}, stage[gi][DATA_WIDTH-1:SH]};
        end
    endgenerate

    assign shifted = stage[ALU_SHAMT_WIDTH];

endmodule

// File: rtl/alu32.sv
// 32-bit execute-stage ALU with registered result and zero flag (one cycle latency).
// Optional registered signed-overflow output when ALU32_OVERFLOW_EN is defined.
module alu32
    import alu32_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int CTRL_WIDTH = ALU_CTRL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [CTRL_WIDTH-1:0] ctrl,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  iszero
`ifdef ALU32_OVERFLOW_EN
    ,
    output logic                  overflow
`endif
);

    logic [DATA_WIDTH-1:0] result_reg, result_next;
    logic                  iszero_reg;
    logic [DATA_WIDTH-1:0] sum, diff, shifted;
    logic [1:0]            shift_mode;

    assign sum  = in1 + in2;
    assign diff = in1 - in2;

    always_comb begin
        shift_mode = SHIFT_SLL;
        if (ctrl == ALU_SRL) shift_mode = SHIFT_SRL;
        else if (ctrl == ALU_SRA) shift_mode = SHIFT_SRA;
    end

    alu32_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
        .data    (in1),
        .shamt   (in2[ALU_SHAMT_WIDTH-1:0]),
        .mode    (shift_mode),
        .shifted (shifted)
    );

    always_comb begin
        result_next = '0;
        case (ctrl)
            ALU_AND:   result_next = in1 & in2;
            ALU_OR:    result_next = in1 | in2;
            ALU_ADD:   result_next = sum;
            ALU_XOR:   result_next = in1 ^ in2;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   result_next = shifted;
            ALU_SUB:   result_next = diff;
            ALU_SLT:   result_next = {{(DATA_WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_PASSA: result_next = in1;
            ALU_PASSB: result_next = in2;
            ALU_LUI:   result_next = {in2[DATA_WIDTH-17:0], 16'h0000};
            ALU_SLTU:  result_next = {{(DATA_WIDTH-1){1'b0}}, (in1 < in2)};
            ALU_NOR:   result_next = ~(in1 | in2);
            default:   result_next = '0;
        endcase
    end

    // Zero flag comes from the same next-state value so it can never disagree with result.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
            iszero_reg <= 1'b1;
        end else begin
            result_reg <= result_next;
            iszero_reg <= (result_next == '0);
        end
    end

    assign result = result_reg;
    assign iszero = iszero_reg;

`ifdef ALU32_OVERFLOW_EN
    logic overflow_reg, overflow_next;

    always_comb begin
        overflow_next = 1'b0;
        if (ctrl == ALU_ADD)
            overflow_next = (in1[DATA_WIDTH-1] == in2[DATA_WIDTH-1]) &&
                            (sum[DATA_WIDTH-1] != in1[DATA_WIDTH-1]);
        else if (ctrl == ALU_SUB)
            overflow_next = (in1[DATA_WIDTH-1] != in2[DATA_WIDTH-1]) &&
                            (diff[DATA_WIDTH-1] != in1[DATA_WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) overflow_reg <= 1'b0;
        else     overflow_reg <= overflow_next;
    end

    assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed test-plan vectors plus randomized ops against a reference model.
// Also checks the overflow output when ALU32_OVERFLOW_EN is defined.
module tb_alu32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in1, in2;
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        iszero;
`ifdef ALU32_OVERFLOW_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    alu32 dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .ctrl   (ctrl),
        .result (result),
        .iszero (iszero)
`ifdef ALU32_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operation definitions.
    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        int unsigned s  = b % 32;
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return a << s;
            4'd5:  return a >> s;
            4'd6:  return a - b;
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return a;
            4'd9:  return b;
            4'd10: return b * 32'd65536;
            4'd11: return (a < b) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
            4'd14: return a[31] ? ~((~a) >> s) : (a >> s);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_overflow(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint r;
        if (op == 4'd2)      r = sa + sb;
        else if (op == 4'd6) r = sa - sb;
        else return 1'b0;
        // Overflow iff the exact result is not representable as a 32-bit signed value.
        return r != longint'($signed(r[31:0]));
    endfunction

    // Apply one operation for a cycle and check the registered outputs just after the edge.
    task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic exp_ovf);
        @(negedge clk);
        ctrl = op; in1 = a; in2 = b;
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d %s ctrl=%b in1=%h in2=%h result=%h iszero=%b", txn, tag, op, a, b,
                 result, iszero);
        check_val({tag, ".result"}, result, exp);
        check_val({tag, ".iszero"}, {31'd0, iszero}, {31'd0, (exp == 32'd0)});
`ifdef ALU32_OVERFLOW_EN
        check_val({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("txn %0d note: unexpected unknown overflow expectation", txn);
`endif
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ovf;
    } vec_t;

    vec_t vecs [$];

    initial begin
        rst = 1'b1; in1 = 32'd39; in2 = 32'd589; ctrl = 4'b0010;

        // Reset holds the outputs at zero despite an active ADD on the inputs.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            txn++;
            $display("txn %0d reset cycle %0d result=%h iszero=%b", txn, i, result, iszero);
            check_val("reset.result", result, 32'd0);
            check_val("reset.iszero", {31'd0, iszero}, 32'd1);
`ifdef ALU32_OVERFLOW_EN
            check_val("reset.overflow", {31'd0, overflow}, 32'd0);
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d release result=%h iszero=%b", txn, result, iszero);
        check_val("release.result", result, 32'd628);
        check_val("release.iszero", {31'd0, iszero}, 32'd0);

        vecs = '{
            '{"and",      4'b0000, 32'd39, 32'd589, 32'd5, 1'b0},
            '{"or",       4'b0001, 32'd39, 32'd589, 32'd623, 1'b0},
            '{"add",      4'b0010, 32'd39, 32'd589, 32'd628, 1'b0},
            '{"xor",      4'b0011, 32'd39, 32'd589, 32'd618, 1'b0},
            '{"sub",      4'b0110, 32'd39, 32'd589, 32'hFFFF_FDDA, 1'b0},
            '{"nor",      4'b1100, 32'd39, 32'd589, 32'hFFFF_FD90, 1'b0},
            '{"sll",      4'b0100, 32'd39, 32'd589, 32'h0004_E000, 1'b0},
            '{"sra",      4'b1110, 32'd39, 32'd589, 32'd0, 1'b0},
            '{"slt",      4'b0111, 32'd39, 32'd589, 32'd1, 1'b0},
            '{"sltu",     4'b1011, 32'd39, 32'd589, 32'd1, 1'b0},
            '{"slt_edge", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0},
            '{"sltu_edge",4'b1011, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0},
            '{"slt_eq",   4'b0111, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0},
            '{"sltu_eq",  4'b1011, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0},
            '{"sra_neg",  4'b1110, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0},
            '{"srl_neg",  4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0},
            '{"srl_31",   4'b0101, 32'h8000_0000, 32'd31, 32'd1, 1'b0},
            '{"sll_by32", 4'b0100, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b0},
            '{"rsv_1101", 4'b1101, 32'd39, 32'd589, 32'd0, 1'b0},
            '{"rsv_1111", 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0},
            '{"sub_eq",   4'b0110, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0},
            '{"passa",    4'b1000, 32'hCAFE_0001, 32'd7, 32'hCAFE_0001, 1'b0},
            '{"passb",    4'b1001, 32'd39, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0},
            '{"lui",      4'b1010, 32'd39, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0},
            '{"add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1},
            '{"sub_ovf",  4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1},
            '{"add_noovf",4'b0010, 32'd39, 32'd589, 32'd628, 1'b0}
        };
        foreach (vecs[i])
            apply(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].ovf);

        // Reset asserted mid-stream must override a nonzero operation.
        @(negedge clk);
        rst = 1'b1; ctrl = 4'b1000; in1 = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d midreset result=%h iszero=%b", txn, result, iszero);
        check_val("midreset.result", result, 32'd0);
        check_val("midreset.iszero", {31'd0, iszero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = $urandom();
            if (i % 4 == 0) a = {a[31], 31'($urandom_range(0, 3))} ^ {1'b0, 31'h7FFF_FFFF};
            if (i % 5 == 0) b = a;
            apply("rand", op, a, b, model_result(op, a, b), model_overflow(op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu32.md
Name: alu32

Overview:
- 32-bit integer ALU for the tinycpu datapath: two operands, 4-bit operation select, registered result plus zero flag.
- Sits in the execute stage between the register-file read ports and the writeback/branch logic.
- Single clock domain; outputs are registered, giving one cycle of latency.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be 32 for the shift-amount rules below.
- CTRL_WIDTH, 4, operation select width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in1  input  DATA_WIDTH  operand A
- in2  input  DATA_WIDTH  operand B (shift amount taken from in2[4:0])
- ctrl  input  CTRL_WIDTH  operation select
- result  output  DATA_WIDTH  registered operation result
- iszero  output  1  registered; 1 when result == 0

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- On a rising clk edge with rst=1: result <= 0, iszero <= 1. Reset dominates all other inputs.
- Otherwise, on every rising edge: result <= f(ctrl, in1, in2) and iszero <= (f == 0). There is no enable, so the outputs track the inputs with exactly 1-cycle latency.
- No handshake. Inputs are sampled every cycle.
- ctrl encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (modulo 2^32)
  - 0011 XOR
  - 0100 SLL: in1 << in2[4:0]
  - 0101 SRL: logical in1 >> in2[4:0]
  - 0110 SUB: in1 - in2, modulo 2^32
  - 0111 SLT: signed in1 < in2 gives 1, else 0
  - 1000 PASSA: in1
  - 1001 PASSB: in2
  - 1010 LUI: in2 << 16
  - 1011 SLTU: unsigned compare, 1 or 0
  - 1100 NOR
  - 1110 SRA: arithmetic in1 >>> in2[4:0]
  - 1101 and 1111: reserved; result = 0, iszero = 1
- Width and boundary rules:
  - ADD and SUB discard the carry.
  - Shift amounts use only in2[4:0]; in2[31:5] are ignored, so a shift by 0 returns in1 unchanged.
  - SRA of a negative value fills with 1s. SRL fills with 0s.
  - SLT and SLTU zero-extend the 1-bit compare to 32 bits.
  - With in1 == in2, SLT and SLTU both give 0.
  - SLT on 0x80000000 vs 0x7FFFFFFF gives 1; SLTU on the same pair gives 0.
- iszero is always derived from the same-cycle registered result; the two never disagree.
- Deassertion of rst: the first post-reset edge loads the computed value.

Optional Feature:
- Macro: ALU32_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit), registered alongside result and reset to 0.
  - ADD: set on signed overflow, i.e. both operands have the same sign and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from in1.
  - All other ops: 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu32_pkg holds:
  - the DATA_WIDTH/CTRL_WIDTH defaults;
  - localparam opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_PASSA, ALU_PASSB, ALU_LUI, ALU_SLTU, ALU_NOR, ALU_SRA);
  - the shift-amount width (5).
- One natural sub-module: alu32_shifter, combinational barrel shifter covering SLL, SRL and SRA, selected by a 2-bit mode. It is instantiated once. All remaining logic lives in alu32.

Test Plan:
- Reset: rst=1 for 2 cycles with in1=39, in2=589, ctrl=0010 -> result=0, iszero=1. Release rst -> next edge result=628, iszero=0.
- Logic and arithmetic with in1=39, in2=589, each result one cycle after ctrl changes:
  - AND -> 5
  - OR -> 623
  - ADD -> 628
  - XOR -> 618
  - SUB -> 0xFFFFFDDA
  - NOR -> 0xFFFFFD90
- Shifts and compares with in1=39, in2=589 (shamt=13):
  - SLL -> 0x0004E000
  - SRA -> 0, iszero=1
  - SLT -> 1
  - SLTU -> 1
- Signed edge cases:
  - in1=0x80000000, in2=0x7FFFFFFF: SLT -> 1, SLTU -> 0.
  - in1=0x80000000, in2=4: SRA -> 0xF8000000, SRL -> 0x08000000.
- Reserved/zero cases:
  - ctrl=1101 -> result=0, iszero=1.
  - SUB with in1=in2=0x12345678 -> 0, iszero=1.
  - PASSB with in2=0x0000FFFF -> 0x0000FFFF.
  - LUI with in2=0x0000FFFF -> 0xFFFF0000.
- ALU32_OVERFLOW_EN:
  - ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1.
  - SUB 0x80000000-1 -> overflow=1.
  - ADD 39+589 -> overflow=0.
